i2s_mic_array_rx: RTL and testbench

- Parametrised multi-channel I2S microphone receiver and clock master for the audio path.
- Generates BCLK and LRCL from the audio clock with a clock-enable divider and drives both to every mic.
- Deserialises NUM_MICS data lines in parallel and captures both the left and right slots, so two mics can share each line via SEL.
- Presents aligned, registered signed samples with per-slot valid strobes to downstream decimation, DSP and display logic.

---
 rtl/i2s_mic_array_rx.sv | 151 +++++++++++++++
 tb/tb_i2s_mic_array_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_array_rx.sv
// Multi-line I2S microphone receiver and BCLK/LRCL clock master.
// Captures left and right slots of NUM_MICS data lines and presents
// registered two's-complement samples with per-slot valid strobes.
module i2s_mic_array_rx #(
  parameter int unsigned NUM_MICS    = 3,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned BCLK_DIV    = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            enable_in,
  input  logic [NUM_MICS-1:0]             data_in,
  output logic                            bclk_out,
  output logic                            lrcl_out,
  output logic [NUM_MICS*SAMPLE_BITS-1:0] left_out,
  output logic [NUM_MICS*SAMPLE_BITS-1:0] right_out,
  output logic                            left_valid_out,
  output logic                            right_valid_out
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_STROBE = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] LAST_CAP   = BIT_W'(SAMPLE_BITS);

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  typedef logic [NUM_MICS-1:0][SAMPLE_BITS-1:0] lanes_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrcl_q, lrcl_d;
  logic             left_valid_q, left_valid_d;
  logic             right_valid_q, right_valid_d;
  lanes_t           left_sr_q, left_sr_d;
  lanes_t           right_sr_q, right_sr_d;
  lanes_t           left_q, left_d;
  lanes_t           right_q, right_d;

  lanes_t           left_shift;
  lanes_t           right_shift;
  slot_e            slot;
  logic [BIT_W-1:0] slot_bit;
  logic             strobe;
  logic             capture;
  logic             last_bit;

  always_comb begin
    slot     = (bit_cnt_q >= SLOT_LEN) ? SLOT_RIGHT : SLOT_LEFT;
    slot_bit = (slot == SLOT_RIGHT) ? (bit_cnt_q - SLOT_LEN) : bit_cnt_q;
    strobe   = enable_in && (div_cnt_q == DIV_STROBE);
    capture  = strobe && (slot_bit != '0) && (slot_bit <= LAST_CAP);
    last_bit = capture && (slot_bit == LAST_CAP);
    for (int unsigned i = 0; i < NUM_MICS; i++) begin
      left_shift[i]  = SAMPLE_BITS'({left_sr_q[i], data_in[i]});
      right_shift[i] = SAMPLE_BITS'({right_sr_q[i], data_in[i]});
    end
  end

  // The final bit is merged straight into the output load so valid trails
  // the last strobe by exactly one cycle.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    left_sr_d     = left_sr_q;
    right_sr_d    = right_sr_q;
    left_d        = left_q;
    right_d       = right_q;
    left_valid_d  = 1'b0;
    right_valid_d = 1'b0;

    if (!enable_in) begin
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      left_sr_d  = '0;
      right_sr_d = '0;
    end else begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      if (capture) begin
        if (slot == SLOT_RIGHT) begin
          right_sr_d = right_shift;
        end else begin
          left_sr_d = left_shift;
        end
      end

      if (last_bit) begin
        if (slot == SLOT_RIGHT) begin
          right_d       = right_shift;
          right_valid_d = 1'b1;
        end else begin
          left_d       = left_shift;
          left_valid_d = 1'b1;
        end
      end
    end

    bclk_d = (div_cnt_d >= DIV_HALF);
    lrcl_d = (bit_cnt_d >= SLOT_LEN);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrcl_q        <= 1'b0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      left_sr_q     <= '0;
      right_sr_q    <= '0;
      left_q        <= '0;
      right_q       <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrcl_q        <= lrcl_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
      left_sr_q     <= left_sr_d;
      right_sr_q    <= right_sr_d;
      left_q        <= left_d;
      right_q       <= right_d;
    end
  end

  assign bclk_out        = bclk_q;
  assign lrcl_out        = lrcl_q;
  assign left_out        = left_q;
  assign right_out       = right_q;
  assign left_valid_out  = left_valid_q;
  assign right_valid_out = right_valid_q;

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
module tb_i2s_mic_array_rx;

  localparam int unsigned NM_A    = 3;
  localparam int unsigned SB_A    = 24;
  localparam int unsigned SLOT_A  = 32;
  localparam int unsigned DIV_A   = 32;
  localparam int unsigned FRAME_A = 2 * SLOT_A * DIV_A;
  localparam int unsigned LVT_A   = SB_A * DIV_A + DIV_A / 2;
  localparam int unsigned RVT_A   = SLOT_A * DIV_A + LVT_A;

  localparam int unsigned NM_B   = 2;
  localparam int unsigned SB_B   = 6;
  localparam int unsigned SLOT_B = 8;
  localparam int unsigned DIV_B  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_a, en_a;
  logic [NM_A-1:0]         data_a;
  logic                    bclk_a, lrcl_a, lv_a, rv_a;
  logic [NM_A*SB_A-1:0]    left_a, right_a;

  logic                    rst_b, en_b;
  logic [NM_B-1:0]         data_b;
  logic                    bclk_b, lrcl_b, lv_b, rv_b;
  logic [NM_B*SB_B-1:0]    left_b, right_b;

  i2s_mic_array_rx dut_a (
    .clk_in(clk), .rst_in(rst_a), .enable_in(en_a), .data_in(data_a),
    .bclk_out(bclk_a), .lrcl_out(lrcl_a), .left_out(left_a), .right_out(right_a),
    .left_valid_out(lv_a), .right_valid_out(rv_a)
  );

  i2s_mic_array_rx #(
    .NUM_MICS(NM_B), .SAMPLE_BITS(SB_B), .SLOT_BITS(SLOT_B), .BCLK_DIV(DIV_B)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b), .enable_in(en_b), .data_in(data_b),
    .bclk_out(bclk_b), .lrcl_out(lrcl_b), .left_out(left_b), .right_out(right_b),
    .left_valid_out(lv_b), .right_valid_out(rv_b)
  );

  typedef struct {
    logic [NM_A-1:0][23:0] l;
    logic [NM_A-1:0][23:0] r;
    bit                    junk;
    logic [71:0]           exp_l;
    logic [71:0]           exp_r;
  } vec_t;

  vec_t vecs[4];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;

  int unsigned m_t;
  bit          m_en_prev;
  logic [71:0] exp_left, exp_right;
  logic [23:0] cur_l[NM_A];
  logic [23:0] cur_r[NM_A];
  bit          cur_junk;
  logic [71:0] cur_exp_l, cur_exp_r;

  task automatic compare(input string name, input logic [147:0] act, input logic [147:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Mic behaviour: bit for time t counted from frame start; sample MSB at slot bit 1.
  function automatic logic drive_bit(input int unsigned t, input int unsigned div,
                                     input int unsigned slot, input int unsigned sb,
                                     input logic [23:0] lv, input logic [23:0] rv,
                                     input bit junk);
    int unsigned pos = (t / div) % (2 * slot);
    int unsigned b   = pos % slot;
    if (b >= 1 && b <= sb)
      return (pos < slot) ? lv[sb-b] : rv[sb-b];
    return junk ? logic'($urandom_range(1, 0)) : 1'b0;
  endfunction

  task automatic tick_a(input bit en);
    logic [147:0] act, exp;
    logic         e_bclk, e_lrcl, e_lv, e_rv;
    m_t    = m_en_prev ? m_t + 1 : 0;
    e_lv   = m_en_prev && (m_t % FRAME_A == LVT_A);
    e_rv   = m_en_prev && (m_t % FRAME_A == RVT_A);
    if (e_lv) exp_left = cur_exp_l;
    if (e_rv) exp_right = cur_exp_r;
    e_bclk = ((m_t % DIV_A) >= DIV_A / 2) ? 1'b1 : 1'b0;
    e_lrcl = ((m_t % FRAME_A) >= SLOT_A * DIV_A) ? 1'b1 : 1'b0;
    exp = {e_bclk, e_lrcl, e_lv, e_rv, exp_left, exp_right};
    act = {bclk_a, lrcl_a, lv_a, rv_a, left_a, right_a};
    compare("dut_a", act, exp);
    en_a = en;
    for (int i = 0; i < NM_A; i++)
      data_a[i] = drive_bit(m_t, DIV_A, SLOT_A, SB_A, cur_l[i], cur_r[i], cur_junk);
    m_en_prev = en;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; en_a = 1'b0; data_a = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    m_en_prev = 1'b0; m_t = 0;
    exp_left = '0; exp_right = '0;
    cyc = 0;
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < NM_A; i++) begin
      cur_l[i] = vecs[k].l[i];
      cur_r[i] = vecs[k].r[i];
    end
    cur_junk  = vecs[k].junk;
    cur_exp_l = vecs[k].exp_l;
    cur_exp_r = vecs[k].exp_r;
  endtask

  task automatic load_random();
    for (int i = 0; i < NM_A; i++) begin
      cur_l[i] = 24'($urandom);
      cur_r[i] = 24'($urandom);
      cur_exp_l[i*24 +: 24] = cur_l[i];
      cur_exp_r[i*24 +: 24] = cur_r[i];
    end
    cur_junk = 1'b1;
  endtask

  initial begin
    logic [5:0]   lb[NM_B];
    logic [147:0] act, exp;

    vecs[0].l = {24'h000000, 24'h000000, 24'h800001};
    vecs[0].r = {24'h000000, 24'h000000, 24'h7FFFFE};
    vecs[0].junk = 1'b0;
    vecs[0].exp_l = 72'h000000_000000_800001;
    vecs[0].exp_r = 72'h000000_000000_7FFFFE;
    vecs[1].l = {24'h000FFF, 24'hABCDEF, 24'h123456};
    vecs[1].r = {24'h00FF00, 24'hF0F0F0, 24'h0F0F0F};
    vecs[1].junk = 1'b0;
    vecs[1].exp_l = 72'h000FFF_ABCDEF_123456;
    vecs[1].exp_r = 72'h00FF00_F0F0F0_0F0F0F;
    vecs[2].l = {24'hFFFFFF, 24'h000000, 24'h5A5A5A};
    vecs[2].r = {24'h000001, 24'h800000, 24'hA5A5A5};
    vecs[2].junk = 1'b1;
    vecs[2].exp_l = 72'hFFFFFF_000000_5A5A5A;
    vecs[2].exp_r = 72'h000001_800000_A5A5A5;
    vecs[3].l = '0;
    vecs[3].r = '0;
    vecs[3].junk = 1'b1;
    vecs[3].exp_l = '0;
    vecs[3].exp_r = '0;

    rst_b = 1'b1; en_b = 1'b0; data_b = '0;

    // Default instance: table frames, then random frames
    reset_a();
    for (int k = 0; k < 4; k++) begin
      load_vec(k);
      repeat (FRAME_A) tick_a(1'b1);
    end
    for (int f = 0; f < 3; f++) begin
      load_random();
      repeat (FRAME_A) tick_a(1'b1);
    end

    // Disable at relative cycle 500, re-enable at 3000
    load_random();
    repeat (500) tick_a(1'b1);
    repeat (2500) tick_a(1'b0);
    load_vec(1);
    repeat (FRAME_A) tick_a(1'b1);

    // Single-cycle enable drop mid-frame restarts the frame
    load_vec(0);
    repeat (300) tick_a(1'b1);
    tick_a(1'b0);
    repeat (FRAME_A) tick_a(1'b1);

    // Small instance: left valid at 26, reset at 40 clears outputs at 41
    lb[0] = 6'h2D;
    lb[1] = 6'h13;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    cyc = 0;
    for (int n = 0; n <= 41; n++) begin
      if (n == 41) begin
        exp = '0;
      end else begin
        exp = '0;
        exp[147] = ((n % DIV_B) >= DIV_B / 2) ? 1'b1 : 1'b0;
        exp[146] = ((n % (2 * SLOT_B * DIV_B)) >= SLOT_B * DIV_B) ? 1'b1 : 1'b0;
        exp[145] = (n == 26) ? 1'b1 : 1'b0;
        exp[144] = 1'b0;
        exp[23:12] = (n >= 26) ? 12'h4ED : 12'h000;
        exp[11:0]  = 12'h000;
      end
      act = '0;
      act[147:144] = {bclk_b, lrcl_b, lv_b, rv_b};
      act[23:12]   = left_b;
      act[11:0]    = right_b;
      compare("dut_b", act, exp);
      rst_b = (n == 40) ? 1'b1 : 1'b0;
      en_b  = 1'b1;
      for (int i = 0; i < NM_B; i++)
        data_b[i] = drive_bit(n, DIV_B, SLOT_B, SB_B, {18'd0, lb[i]}, 24'd0, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
